// File: rtl/usb4_pma_rx_mrgn_responder.sv
// PMA-side Rx margining responder: applies a clamped eye-monitor offset, waits a settle
// time, then counts comparator errors over a dwell window and reports a saturating count.
module usb4_pma_rx_mrgn_responder (
    input  logic        pipe_mac2phy_clk,
    input  logic        pipe_mac2phy_rstn,
    input  logic        mrgn_enable,
    input  logic        rx_signal_detect,
    input  logic        rx_mrgn_req,
    input  logic [1:0]  rx_mrgn_dir,
    input  logic [6:0]  rx_mrgn_offset,
    input  logic [7:0]  cfg_settle_cnt,
    input  logic [15:0] cfg_dwell_cnt,
    input  logic [6:0]  cfg_max_offset,
    input  logic        err_pulse,
    output logic        rx_mrgn_valid,
    output logic [5:0]  rx_mrgn_errcnt,
    output logic        ana_mrgn_en,
    output logic [1:0]  ana_mrgn_dir,
    output logic [6:0]  ana_mrgn_offset,
    output logic        mrgn_clamped
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_SETTLE = 3'd1;
    localparam logic [2:0] ST_COUNT  = 3'd2;
    localparam logic [2:0] ST_VALID  = 3'd3;
    localparam logic [2:0] ST_RETURN = 3'd4;

    localparam logic [5:0] ERR_MAX = 6'd63;

    logic [2:0]  r_state;
    logic [7:0]  r_settle_cnt;
    logic [15:0] r_dwell_cnt;
    logic [5:0]  r_errcnt;
    logic        r_valid;
    logic        r_ana_en;
    logic [1:0]  r_ana_dir;
    logic [6:0]  r_ana_offset;
    logic        r_clamped;

    logic        w_abort;
    logic        w_clamp;
    logic [6:0]  w_offset_applied;
    logic [5:0]  w_errcnt_next;
    logic        w_settle_done;
    logic        w_count_done;

    assign w_abort          = ~mrgn_enable | ~rx_signal_detect;
    assign w_clamp          = rx_mrgn_offset > cfg_max_offset;
    assign w_offset_applied = w_clamp ? cfg_max_offset : rx_mrgn_offset;
    assign w_settle_done    = r_settle_cnt == cfg_settle_cnt;

    // Early exit looks at the post-increment count so a saturating error burst ends the window at once.
    assign w_errcnt_next = (err_pulse && (r_errcnt != ERR_MAX)) ? r_errcnt + 6'd1 : r_errcnt;
    assign w_count_done  = (r_dwell_cnt == cfg_dwell_cnt) || (w_errcnt_next == ERR_MAX);

    always_ff @(posedge pipe_mac2phy_clk or negedge pipe_mac2phy_rstn) begin
        if (!pipe_mac2phy_rstn) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= 8'd0;
            r_dwell_cnt  <= 16'd0;
            r_errcnt     <= 6'd0;
            r_valid      <= 1'b0;
            r_ana_en     <= 1'b0;
            r_ana_dir    <= 2'd0;
            r_ana_offset <= 7'd0;
            r_clamped    <= 1'b0;
        end else if (w_abort) begin
            r_state      <= ST_IDLE;
            r_settle_cnt <= 8'd0;
            r_dwell_cnt  <= 16'd0;
            r_valid      <= 1'b0;
            r_ana_en     <= 1'b0;
            r_ana_offset <= 7'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (rx_mrgn_req) begin
                        r_state      <= ST_SETTLE;
                        r_ana_en     <= 1'b1;
                        r_ana_dir    <= rx_mrgn_dir;
                        r_ana_offset <= w_offset_applied;
                        r_clamped    <= w_clamp;
                        r_errcnt     <= 6'd0;
                        r_settle_cnt <= 8'd0;
                    end
                end
                ST_SETTLE: begin
                    if (!rx_mrgn_req) begin
                        r_state      <= ST_RETURN;
                        r_ana_en     <= 1'b0;
                        r_ana_offset <= 7'd0;
                    end else if (w_settle_done) begin
                        r_state     <= ST_COUNT;
                        r_dwell_cnt <= 16'd0;
                    end else begin
                        r_settle_cnt <= r_settle_cnt + 8'd1;
                    end
                end
                ST_COUNT: begin
                    r_errcnt <= w_errcnt_next;
                    if (!rx_mrgn_req) begin
                        r_state      <= ST_RETURN;
                        r_ana_en     <= 1'b0;
                        r_ana_offset <= 7'd0;
                    end else if (w_count_done) begin
                        r_state <= ST_VALID;
                        r_valid <= 1'b1;
                    end else begin
                        r_dwell_cnt <= r_dwell_cnt + 16'd1;
                    end
                end
                ST_VALID: begin
                    if (!rx_mrgn_req) begin
                        r_state      <= ST_RETURN;
                        r_valid      <= 1'b0;
                        r_ana_en     <= 1'b0;
                        r_ana_offset <= 7'd0;
                    end
                end
                ST_RETURN: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state      <= ST_IDLE;
                    r_valid      <= 1'b0;
                    r_ana_en     <= 1'b0;
                    r_ana_offset <= 7'd0;
                end
            endcase
        end
    end

    assign rx_mrgn_valid   = r_valid;
    assign rx_mrgn_errcnt  = r_errcnt;
    assign ana_mrgn_en     = r_ana_en;
    assign ana_mrgn_dir    = r_ana_dir;
    assign ana_mrgn_offset = r_ana_offset;
    assign mrgn_clamped    = r_clamped;

endmodule

// File: tb/tb_usb4_pma_rx_mrgn_responder.sv
// Directed scoreboard bench for usb4_pma_rx_mrgn_responder: expected results are queued
// when a request is issued and compared when rx_mrgn_valid is observed.
module tb_usb4_pma_rx_mrgn_responder;

    typedef struct {
        int         lat;
        logic [5:0] err;
        logic [6:0] off;
        logic       cl;
        logic [1:0] dir;
    } exp_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        mrgnEnable = 1'b1;
    logic        sigDet = 1'b1;
    logic        req = 1'b0;
    logic [1:0]  dir = 2'd0;
    logic [6:0]  off = 7'd0;
    logic [7:0]  settle = 8'd0;
    logic [15:0] dwell = 16'd0;
    logic [6:0]  maxOff = 7'd127;
    logic        errPulse = 1'b0;

    logic        valid;
    logic [5:0]  errcnt;
    logic        anaEn;
    logic [1:0]  anaDir;
    logic [6:0]  anaOffset;
    logic        clamped;

    int checks = 0;
    int passes = 0;
    int fails  = 0;
    exp_t sbq[$];

    usb4_pma_rx_mrgn_responder dut (
        .pipe_mac2phy_clk (clk),
        .pipe_mac2phy_rstn(rstn),
        .mrgn_enable      (mrgnEnable),
        .rx_signal_detect (sigDet),
        .rx_mrgn_req      (req),
        .rx_mrgn_dir      (dir),
        .rx_mrgn_offset   (off),
        .cfg_settle_cnt   (settle),
        .cfg_dwell_cnt    (dwell),
        .cfg_max_offset   (maxOff),
        .err_pulse        (errPulse),
        .rx_mrgn_valid    (valid),
        .rx_mrgn_errcnt   (errcnt),
        .ana_mrgn_en      (anaEn),
        .ana_mrgn_dir     (anaDir),
        .ana_mrgn_offset  (anaOffset),
        .mrgn_clamped     (clamped)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issues one request and runs it to the result; err_pulse is high before edges errFrom..errTo after E0.
    task automatic applyStimulus(input int s, input int d, input logic [1:0] dr, input logic [6:0] o,
                                 input logic [6:0] mx, input int errFrom, input int errTo, input string tag);
        exp_t e;
        int   cnt;
        int   k;
        bit   seen;
        e.dir = dr;
        e.cl  = (o > mx);
        e.off = e.cl ? mx : o;
        e.lat = s + d + 2;
        cnt   = 0;
        for (int j = s + 2; j <= s + d + 2; j++) begin
            if (j >= errFrom && j <= errTo && cnt < 63) cnt++;
            if (cnt == 63) begin
                e.lat = j;
                break;
            end
        end
        e.err = cnt[5:0];
        sbq.push_back(e);

        settle   = s[7:0];
        dwell    = d[15:0];
        dir      = dr;
        off      = o;
        maxOff   = mx;
        errPulse = 1'b0;
        req      = 1'b1;
        tick;
        checkOutput({tag, " ana_en"}, anaEn, 1);
        checkOutput({tag, " ana_dir"}, anaDir, dr);
        checkOutput({tag, " ana_offset"}, anaOffset, e.off);
        checkOutput({tag, " clamped"}, clamped, e.cl);
        dir = ~dr;
        off = ~o;

        seen = 0;
        k    = 0;
        while (!seen && k < 2000) begin
            k++;
            errPulse = (k >= errFrom && k <= errTo);
            tick;
            if (valid === 1'b1) seen = 1;
        end
        errPulse = 1'b0;

        e = sbq.pop_front();
        checkOutput({tag, " valid latency"}, seen ? k : -1, e.lat);
        checkOutput({tag, " errcnt"}, errcnt, e.err);
        checkOutput({tag, " offset held"}, anaOffset, e.off);
        checkOutput({tag, " dir held"}, anaDir, e.dir);

        errPulse = 1'b1;
        tick;
        tick;
        errPulse = 1'b0;
        checkOutput({tag, " valid stays"}, valid, 1);
        checkOutput({tag, " errcnt stable"}, errcnt, e.err);
    endtask

    task automatic endTxn(input string tag);
        req = 1'b0;
        tick;
        checkOutput({tag, " valid fall"}, valid, 0);
        checkOutput({tag, " ana_en off"}, anaEn, 0);
        checkOutput({tag, " offset off"}, anaOffset, 0);
        tick;
    endtask

    initial begin
        bit sawValid;

        tick;
        checkOutput("reset valid", valid, 0);
        checkOutput("reset errcnt", errcnt, 0);
        checkOutput("reset ana_en", anaEn, 0);
        checkOutput("reset ana_dir", anaDir, 0);
        checkOutput("reset offset", anaOffset, 0);
        checkOutput("reset clamped", clamped, 0);
        rstn = 1'b1;
        tick;

        applyStimulus(3, 15, 2'b01, 7'd20, 7'd127, 8, 12, "nominal");
        endTxn("nominal");

        applyStimulus(2, 6, 2'b10, 7'd100, 7'd64, 4, 4, "clamp");
        endTxn("clamp");

        applyStimulus(1, 3, 2'b11, 7'd64, 7'd64, 0, -1, "no clamp at max");
        endTxn("no clamp at max");

        applyStimulus(3, 1000, 2'b00, 7'd5, 7'd127, 1, 100000, "saturate");
        endTxn("saturate");

        applyStimulus(0, 0, 2'b01, 7'd1, 7'd127, 2, 2, "min txn");
        endTxn("min txn");

        // Withdrawal during COUNT, with a request re-raised while in RETURN.
        settle   = 8'd2;
        dwell    = 16'd50;
        dir      = 2'b10;
        off      = 7'd9;
        maxOff   = 7'd127;
        req      = 1'b1;
        sawValid = 0;
        tick;
        errPulse = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick;
            if (valid !== 1'b0) sawValid = 1;
        end
        errPulse = 1'b0;
        req = 1'b0;
        tick;
        if (valid !== 1'b0) sawValid = 1;
        checkOutput("withdraw ana_en", anaEn, 0);
        req = 1'b1;
        tick;
        if (valid !== 1'b0) sawValid = 1;
        checkOutput("withdraw return ignores req", anaEn, 0);
        checkOutput("withdraw never valid", sawValid, 0);
        tick;
        checkOutput("withdraw reaccept", anaEn, 1);
        req = 1'b0;
        tick;
        tick;

        // Signal-detect loss while the result is being presented.
        applyStimulus(1, 4, 2'b10, 7'd10, 7'd127, 4, 5, "abort");
        sigDet = 1'b0;
        tick;
        checkOutput("abort valid", valid, 0);
        checkOutput("abort ana_en", anaEn, 0);
        checkOutput("abort offset", anaOffset, 0);
        checkOutput("abort dir held", anaDir, 2'b10);
        checkOutput("abort errcnt held", errcnt, 2);
        tick;
        checkOutput("abort no accept", anaEn, 0);
        sigDet = 1'b1;
        tick;
        checkOutput("abort accept after detect", anaEn, 1);
        req = 1'b0;
        tick;
        tick;

        // Asynchronous reset in the middle of COUNT.
        settle = 8'd0;
        dwell  = 16'd100;
        dir    = 2'b11;
        off    = 7'd100;
        maxOff = 7'd30;
        req    = 1'b1;
        tick;
        errPulse = 1'b1;
        for (int i = 0; i < 5; i++) tick;
        errPulse = 1'b0;
        #2 rstn = 1'b0;
        #1;
        checkOutput("async rst valid", valid, 0);
        checkOutput("async rst errcnt", errcnt, 0);
        checkOutput("async rst ana_en", anaEn, 0);
        checkOutput("async rst ana_dir", anaDir, 0);
        checkOutput("async rst offset", anaOffset, 0);
        checkOutput("async rst clamped", clamped, 0);
        req = 1'b0;
        tick;
        rstn = 1'b1;
        tick;

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
